// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8-bit LSB-first UART transmitter with selectable baud, parity, stop bits
// and CTS flow control; serial_out trails the state register by one clock.
module uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] usr_options,
    input  logic [7:0] tx_data,
    input  logic       tx_write,
    input  logic       peer_ready,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_overflow,
    output logic       tx_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_FREQ / 9600 + 1);
    localparam logic [CW-1:0] DIV_9600   = CW'(CLK_FREQ / 9600);
    localparam logic [CW-1:0] DIV_19200  = CW'(CLK_FREQ / 19200);
    localparam logic [CW-1:0] DIV_57600  = CW'(CLK_FREQ / 57600);
    localparam logic [CW-1:0] DIV_115200 = CW'(CLK_FREQ / 115200);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    logic          pr_meta_q, pr_sync_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q, div_sel;
    logic [7:0]    shift_q, head;
    logic [2:0]    bit_idx_q;
    logic [1:0]    baud_q;
    logic          parity_q, par_en_q, two_stop_q, serial_out_q, done_q;
    logic          full, empty, pop, push, bit_end, line_d;
    logic          unused_opts;

    assign unused_opts = ^usr_options[7:5];

    assign full     = count_q == (AW+1)'(FIFO_DEPTH);
    assign empty    = count_q == '0;
    assign pop      = state_q == IDLE && !empty && pr_sync_q;
    assign push     = tx_write && (!full || pop);
    assign head     = mem_q[rd_ptr_q];
    assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_comb begin
        div_sel = baud_q == 2'b11 ? DIV_115200 :
                  baud_q == 2'b10 ? DIV_57600  :
                  baud_q == 2'b01 ? DIV_19200  : DIV_9600;
        bit_end = cnt_q == div_sel - 1'b1;
        line_d  = state_q == START  ? 1'b0     :
                  state_q == DATA   ? shift_q[0] :
                  state_q == PARITY ? parity_q : 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pr_meta_q <= 1'b0;
            pr_sync_q <= 1'b0;
        end else begin
            pr_meta_q <= peer_ready;
            pr_sync_q <= pr_meta_q;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    // A write while full is still accepted when the same cycle pops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= tx_write && full && !pop;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            baud_q       <= '0;
            parity_q     <= 1'b0;
            par_en_q     <= 1'b0;
            two_stop_q   <= 1'b0;
            serial_out_q <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            serial_out_q <= line_d;
            done_q       <= 1'b0;
            cnt_q        <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
            case (state_q)
                IDLE: if (pop) begin
                    shift_q    <= head;
                    baud_q     <= usr_options[1:0];
                    par_en_q   <= usr_options[3] ^ usr_options[2];
                    parity_q   <= ^head ^ (usr_options[3:2] == 2'b10);
                    two_stop_q <= usr_options[4];
                    state_q    <= START;
                end
                START: if (bit_end) begin
                    bit_idx_q <= '0;
                    state_q   <= DATA;
                end
                DATA: if (bit_end) begin
                    shift_q   <= shift_q >> 1;
                    bit_idx_q <= bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_q <= par_en_q ? PARITY : STOP1;
                end
                PARITY: if (bit_end) state_q <= STOP1;
                STOP1: if (bit_end) begin
                    state_q <= two_stop_q ? STOP2 : IDLE;
                    done_q  <= !two_stop_q;
                end
                STOP2: if (bit_end) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign serial_out  = serial_out_q;
    assign tx_busy     = !empty || state_q != IDLE;
    assign tx_full     = full;
    assign tx_empty    = empty;
    assign tx_overflow = overflow_q;
    assign tx_done     = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench; expected frames are queued at write time and compared
// bit by bit (every clock of every bit) as the line is observed.
module tb_uart_tx;
    localparam int CLK_FREQ = 1152000;
    localparam int DEPTH    = 4;

    logic       clock = 1'b0, reset = 1'b1;
    logic [7:0] usr_options = 8'h03, tx_data = 8'h00;
    logic       tx_write = 1'b0, peer_ready = 1'b1;
    logic       serial_out, tx_busy, tx_full, tx_empty, tx_overflow, tx_done;

    uart_tx #(.CLK_FREQ(CLK_FREQ), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .usr_options(usr_options), .tx_data(tx_data),
        .tx_write(tx_write), .peer_ready(peer_ready), .serial_out(serial_out),
        .tx_busy(tx_busy), .tx_full(tx_full), .tx_empty(tx_empty),
        .tx_overflow(tx_overflow), .tx_done(tx_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        logic [1:0] par;
        logic       two;
    } frame_t;

    frame_t exp_q[$];
    int     falls[$];
    int     errors = 0, checks = 0;
    int     frames_done = 0, ovf_cnt = 0, cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int flen(input frame_t f);
        return 10 + ((f.par == 2'b01 || f.par == 2'b10) ? 1 : 0) + (f.two ? 1 : 0);
    endfunction

    function automatic logic [11:0] fbits(input frame_t f);
        logic [11:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = f.d;
        if (f.par == 2'b01) b[9] = ^f.d;
        if (f.par == 2'b10) b[9] = ~^f.d;
        return b;
    endfunction

    task automatic push_exp(input logic [7:0] d);
        exp_q.push_back('{d, usr_options[3:2], usr_options[4]});
    endtask

    task automatic wr(input logic [7:0] d);
        @(posedge clock);
        #1 tx_data = d; tx_write = 1'b1;
        @(posedge clock);
        #1 tx_write = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (frames_done < n && t < budget) begin
            @(posedge clock);
            t++;
        end
        check("frame_timeout", 32'(frames_done >= n), 1);
    endtask

    task automatic run_frame();
        frame_t      f;
        logic [11:0] obs = '1, expb;
        int          len, bad = 0, done_k = -1;
        bit          abort = 0;
        falls.push_back(cyc);
        if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            return;
        end
        f    = exp_q.pop_front();
        len  = flen(f);
        expb = fbits(f);
        for (int k = 0; k < len * 10; k++) begin
            if (k > 0) @(negedge clock);
            if (reset) begin
                abort = 1;
                break;
            end
            if (tx_done && done_k < 0) done_k = k;
            if (k % 10 == 5) obs[k/10] = serial_out;
            if (serial_out !== expb[k/10]) bad++;
        end
        if (!abort) begin
            check("frame_bits", 32'(obs), 32'(expb));
            check("bit_width_errs", bad, 0);
            check("done_pos", done_k, len * 10 - 1);
            frames_done++;
        end
    endtask

    always @(posedge clock) cyc++;
    always @(negedge clock) if (tx_overflow) ovf_cnt++;

    initial begin : monitor
        logic prev = 1'b1;
        forever begin
            @(negedge clock);
            if (!reset && prev && !serial_out) run_frame();
            prev = serial_out;
        end
    end

    initial begin : stim
        logic [7:0] burst [5] = '{8'h11, 8'h22, 8'h3C, 8'h80, 8'hFF};
        int n0, lows;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_serial_out", serial_out, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_full", tx_full, 0);
        check("rst_empty", tx_empty, 1);
        check("rst_overflow", tx_overflow, 0);
        check("rst_done", tx_done, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(posedge clock);

        usr_options = 8'h03;
        push_exp(8'hA5);
        wr(8'hA5);
        @(negedge clock);
        check("busy_after_write", tx_busy, 1);
        @(negedge clock);
        check("lat_edge1_high", serial_out, 1);
        @(negedge clock);
        check("lat_edge2_low", serial_out, 0);
        wait_frames(1, 200);
        @(negedge clock);
        check("busy_after_frame", tx_busy, 0);

        usr_options = 8'h07;
        push_exp(8'h07);
        wr(8'h07);
        wait_frames(2, 200);
        usr_options = 8'h0B;
        push_exp(8'h07);
        wr(8'h07);
        wait_frames(3, 200);

        usr_options = 8'h13;
        push_exp(8'h00);
        wr(8'h00);
        repeat (30) @(posedge clock);
        usr_options = 8'h03;
        wait_frames(4, 200);

        peer_ready = 1'b0;
        repeat (4) @(posedge clock);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1 tx_data = burst[i]; tx_write = 1'b1;
            if (i < 4) push_exp(burst[i]);
        end
        @(posedge clock);
        #1 tx_write = 1'b0;
        repeat (2) @(negedge clock);
        check("burst_full", tx_full, 1);
        check("burst_empty", tx_empty, 0);
        check("burst_busy", tx_busy, 1);
        check("overflow_pulses", ovf_cnt, 1);
        n0 = falls.size();
        peer_ready = 1'b1;
        wait_frames(8, 700);
        check("burst_frames", falls.size() - n0, 4);
        for (int i = 1; i < 4; i++)
            if (n0 + i < falls.size()) check("b2b_gap", falls[n0+i] - falls[n0+i-1], 101);

        push_exp(8'h5A);
        wr(8'h5A);
        push_exp(8'hC3);
        wr(8'hC3);
        repeat (40) @(posedge clock);
        peer_ready = 1'b0;
        wait_frames(9, 200);
        repeat (150) @(posedge clock);
        @(negedge clock);
        check("held_frames", frames_done, 9);
        check("held_empty", tx_empty, 0);
        check("held_line", serial_out, 1);
        peer_ready = 1'b1;
        wait_frames(10, 200);

        push_exp(8'h96);
        wr(8'h96);
        repeat (40) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_serial_out", serial_out, 1);
        check("abort_empty", tx_empty, 1);
        check("abort_busy", tx_busy, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        lows = 0;
        repeat (30) begin
            @(negedge clock);
            if (!serial_out) lows++;
        end
        check("idle_after_reset", lows, 0);
        check("frames_after_reset", frames_done, 10);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit half of the RS-232 link that pairs with the existing UART receive path.
- Accepts bytes written by the Nios PIO into a small FIFO and serialises them on serial_out as 8-bit LSB-first frames.
- Baud rate, parity and stop bits come from the same usr_options byte the receive path uses.
- Honours the peer's flow-control line before starting each frame.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz; bit divisor = CLK_FREQ / selected baud, truncated.
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, minimum 2.

Ports:
- clock  in  1  system clock, all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- usr_options  in  8  [1:0] baud (00=9600, 01=19200, 10=57600, 11=115200); [3:2] parity (00=none, 01=even, 10=odd, 11=none); [4] 1=two stop bits; [7:5] reserved, ignored
- tx_data  in  8  byte to send
- tx_write  in  1  one-cycle strobe; pushes tx_data into the FIFO
- peer_ready  in  1  remote CTS, active-high, asynchronous to clock
- serial_out  out  1  line output; idle level 1
- tx_busy  out  1  1 when the FIFO is non-empty or a frame is in progress
- tx_full  out  1  FIFO full
- tx_empty  out  1  FIFO empty
- tx_overflow  out  1  one-cycle pulse when a write is dropped
- tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit

Behaviour:
- Reset values: serial_out=1, tx_busy=0, tx_full=0, tx_empty=1, tx_overflow=0, tx_done=0. FIFO pointers and count are cleared, state goes to IDLE, and the baud counter is 0.
- Reset asserted mid-frame aborts the frame immediately; serial_out returns to 1 asynchronously.
- peer_ready passes through a 2-FF synchroniser (peer_ready_s) before use.
- FIFO write:
  - tx_write with the FIFO not full stores tx_data.
  - tx_write with the FIFO full drops the byte and pulses tx_overflow the next cycle.
  - A write and a pop in the same cycle while full are both accepted; the count is unchanged and there is no overflow.
- Frame format: start(0), D0..D7, optional parity bit, stop(1), optional second stop(1).
  - Even parity: the parity bit makes the count of ones across data plus parity even.
  - Odd parity: the parity bit makes that count odd.
- Options are latched at the IDLE->START transition. Changes to usr_options mid-frame have no effect until the next frame.
- Baud counter:
  - Runs 0..DIV-1 with DIV = CLK_FREQ/baud.
  - Every bit lasts exactly DIV clocks.
  - The bit advances when the counter is at DIV-1, and the counter then wraps to 0.
- State machine (serial_out is registered):
  - IDLE: serial_out=1. If the FIFO is non-empty and peer_ready_s=1: pop the FIFO into the shift register, latch options, and go to START.
  - START: serial_out=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: serial_out=shift[0] for DIV clocks per bit, shifting right each bit. After bit 7, go to PARITY if parity is enabled, else STOP1.
  - PARITY: drive the computed parity bit for DIV clocks, then go to STOP1.
  - STOP1: serial_out=1 for DIV clocks. Then go to STOP2 if two stop bits are latched; otherwise pulse tx_done and go to IDLE.
  - STOP2: serial_out=1 for DIV clocks, then pulse tx_done and go to IDLE.
- Back-to-back frames: if the FIFO is non-empty and peer_ready_s=1 when a frame ends, IDLE lasts exactly 1 clock before the next start bit.
- Flow control: peer_ready_s is checked only in IDLE. Deassertion mid-frame does not abort; the current frame completes and the next is held.
- Latency: tx_write sampled at edge N, FIFO empty, IDLE, peer_ready_s=1 → serial_out falls at edge N+2.

Test Plan (CLK_FREQ=1152000 so that baud 11 gives DIV=10):
- Reset, then usr_options=8'h03, write 8'hA5 → serial_out low at write+2, bit sequence 0,1,0,1,0,0,1,0,1,1 with each bit 10 clocks. tx_done pulses after 100 clocks of frame; tx_busy then 0.
- usr_options=8'h07 (even parity), write 8'h07 → parity bit 1, frame 110 clocks. usr_options=8'h0B (odd parity), write 8'h07 → parity bit 0.
- usr_options=8'h13 (two stops), write 8'h00 → 110-clock frame. Change usr_options to 8'h03 mid-frame → current frame still has two stop bits.
- Write 5 bytes on consecutive clocks with peer_ready=0 → 4 stored, tx_full=1, tx_overflow pulses once. Raise peer_ready → 4 frames sent with 1 idle clock between them, bytes in write order.
- Drop peer_ready during the DATA state of frame 1 of 2 → frame 1 completes and frame 2 is held until peer_ready=1. Assert reset mid-frame → serial_out=1 immediately, tx_empty=1.
